// File: rtl/dma_burst_engine.sv
// dma_burst_engine: runs one {opcode,addr} command at a time, moving READ bursts from memory into FIFO1
// and WRITE bursts from FIFO2 out to memory over a valid/ready port with separate read/write channels.
// Ports:
//   i_clk, i_rst_n                      clock; asynchronous reset, active-high (asserted = 1)
//   i_cmd_valid/o_cmd_ready/i_cmd_data  command handshake, data = {opcode, addr}; accepted only in IDLE
//   o_mem_ar*, i_mem_arready            read request (address, length = RD_BEATS-1)
//   i_mem_rvalid/o_mem_rready/i_mem_rdata  read beats
//   o_mem_aw*, i_mem_awready            write request (address, length = WR_BEATS-1)
//   o_mem_wvalid/i_mem_wready/o_mem_wdata/o_mem_wlast  write beats
//   o_fifo1_din/o_fifo1_wr_en/i_fifo1_full  FIFO1 push side (read data towards the AP)
//   i_fifo2_dout/o_fifo2_rd_en/i_fifo2_empty  FIFO2 pop side, first-word-fall-through (write data from the AP)
//   o_busy, o_done, o_err_op            not-idle flag, burst-complete pulse, illegal-opcode pulse
module dma_burst_engine #(
    parameter int ISA      = 2,
    parameter int ADDR     = 32,
    parameter int BITLEN   = 64,
    parameter int RD_BEATS = 8,
    parameter int WR_BEATS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ISA+ADDR-1:0]   i_cmd_data,
    output logic                  o_mem_arvalid,
    input  logic                  i_mem_arready,
    output logic [ADDR-1:0]       o_mem_araddr,
    output logic [7:0]            o_mem_arlen,
    input  logic                  i_mem_rvalid,
    output logic                  o_mem_rready,
    input  logic [BITLEN-1:0]     i_mem_rdata,
    output logic                  o_mem_awvalid,
    input  logic                  i_mem_awready,
    output logic [ADDR-1:0]       o_mem_awaddr,
    output logic [7:0]            o_mem_awlen,
    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    output logic [BITLEN-1:0]     o_mem_wdata,
    output logic                  o_mem_wlast,
    output logic [BITLEN-1:0]     o_fifo1_din,
    output logic                  o_fifo1_wr_en,
    input  logic                  i_fifo1_full,
    input  logic [BITLEN-1:0]     i_fifo2_dout,
    output logic                  o_fifo2_rd_en,
    input  logic                  i_fifo2_empty,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_op
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA} state_t;

    localparam logic [ISA-1:0] OP_RD   = ISA'(1);
    localparam logic [ISA-1:0] OP_WR   = ISA'(2);
    localparam logic [7:0]     RD_LAST = 8'(RD_BEATS - 1);
    localparam logic [7:0]     WR_LAST = 8'(WR_BEATS - 1);

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_beat_cnt, w_beat_nxt;
    logic            r_arvalid, w_arvalid_nxt;
    logic            r_awvalid, w_awvalid_nxt;
    logic [ADDR-1:0] r_araddr, w_araddr_nxt;
    logic [ADDR-1:0] r_awaddr, w_awaddr_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err_op, w_err_nxt;

    logic [ISA-1:0]  w_op;
    logic [ADDR-1:0] w_addr;
    logic            w_rd_beat;
    logic            w_wr_beat;

    assign w_op      = i_cmd_data[ISA+ADDR-1:ADDR];
    assign w_addr    = i_cmd_data[ADDR-1:0];
    // rready is withheld while FIFO1 is full, so a read beat can never be pushed into a full FIFO
    assign w_rd_beat = (r_state == RD_DATA) && i_mem_rvalid && !i_fifo1_full;
    // FIFO2 pops only on an accepted write beat, keeping FIFO and memory in lock-step
    assign w_wr_beat = (r_state == WR_DATA) && !i_fifo2_empty && i_mem_wready;

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_araddr   <= '0;
            r_awaddr   <= '0;
            r_done     <= 1'b0;
            r_err_op   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_arvalid  <= w_arvalid_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_araddr   <= w_araddr_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_done     <= w_done_nxt;
            r_err_op   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat_cnt;
        w_arvalid_nxt = r_arvalid;
        w_awvalid_nxt = r_awvalid;
        w_araddr_nxt  = r_araddr;
        w_awaddr_nxt  = r_awaddr;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (w_op == OP_RD) begin
                        w_state_nxt   = RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = w_addr;
                    end else if (w_op == OP_WR) begin
                        w_state_nxt   = WR_ADDR;
                        w_awvalid_nxt = 1'b1;
                        w_awaddr_nxt  = w_addr;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (i_mem_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_beat_nxt    = '0;
                    w_state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_rd_beat) begin
                    w_beat_nxt = r_beat_cnt + 8'd1;
                    if (r_beat_cnt == RD_LAST) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (i_mem_awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_beat_nxt    = '0;
                    w_state_nxt   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_wr_beat) begin
                    w_beat_nxt = r_beat_cnt + 8'd1;
                    if (r_beat_cnt == WR_LAST) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_cmd_ready   = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_mem_arvalid = r_arvalid;
    assign o_mem_araddr  = r_araddr;
    assign o_mem_arlen   = RD_LAST;
    assign o_mem_awvalid = r_awvalid;
    assign o_mem_awaddr  = r_awaddr;
    assign o_mem_awlen   = WR_LAST;
    assign o_mem_rready  = (r_state == RD_DATA) && !i_fifo1_full;
    assign o_fifo1_wr_en = w_rd_beat;
    assign o_fifo1_din   = i_mem_rdata;
    assign o_mem_wvalid  = (r_state == WR_DATA) && !i_fifo2_empty;
    assign o_mem_wdata   = i_fifo2_dout;
    assign o_mem_wlast   = o_mem_wvalid && (r_beat_cnt == WR_LAST);
    assign o_fifo2_rd_en = w_wr_beat;
    assign o_done        = r_done;
    assign o_err_op      = r_err_op;
endmodule

// File: tb/tb_dma_burst_engine.sv
// tb_dma_burst_engine: randomized bench for dma_burst_engine against queue-based memory and FIFO models
module tb_dma_burst_engine;
    logic        clk = 0, rst = 0;
    logic        cmd_valid = 0, cmd_ready;
    logic [33:0] cmd_data = '0;
    logic        mem_arvalid, mem_arready = 0;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid = 0, mem_rready;
    logic [63:0] mem_rdata = '0;
    logic        mem_awvalid, mem_awready = 0;
    logic [31:0] mem_awaddr;
    logic [7:0]  mem_awlen;
    logic        mem_wvalid, mem_wready = 0, mem_wlast;
    logic [63:0] mem_wdata;
    logic [63:0] fifo1_din;
    logic        fifo1_wr_en, fifo1_full = 0;
    logic [63:0] fifo2_dout = '0;
    logic        fifo2_rd_en, fifo2_empty = 1;
    logic        busy, done, err_op;

    int          checks = 0, errors = 0, done_cnt = 0, pops = 0;
    logic [63:0] exp1[$], got1[$], exp2[$], q2[$], wgot[$];
    bit          wlast_q[$];
    logic [31:0] ax_addr;
    logic [7:0]  ax_len;
    logic        done_now;

    dma_burst_engine #(.ISA(2), .ADDR(32), .BITLEN(64), .RD_BEATS(8), .WR_BEATS(16)) dut (
        .i_clk(clk), .i_rst_n(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_data(cmd_data),
        .o_mem_arvalid(mem_arvalid), .i_mem_arready(mem_arready), .o_mem_araddr(mem_araddr), .o_mem_arlen(mem_arlen),
        .i_mem_rvalid(mem_rvalid), .o_mem_rready(mem_rready), .i_mem_rdata(mem_rdata),
        .o_mem_awvalid(mem_awvalid), .i_mem_awready(mem_awready), .o_mem_awaddr(mem_awaddr), .o_mem_awlen(mem_awlen),
        .o_mem_wvalid(mem_wvalid), .i_mem_wready(mem_wready), .o_mem_wdata(mem_wdata), .o_mem_wlast(mem_wlast),
        .o_fifo1_din(fifo1_din), .o_fifo1_wr_en(fifo1_wr_en), .i_fifo1_full(fifo1_full),
        .i_fifo2_dout(fifo2_dout), .o_fifo2_rd_en(fifo2_rd_en), .i_fifo2_empty(fifo2_empty),
        .o_busy(busy), .o_done(done), .o_err_op(err_op)
    );

    always #5 clk = ~clk;

    // FIFO1 sink, FIFO2 source and memory write sink, all updated on the DUT's clock edge
    always @(posedge clk) begin
        if (fifo1_wr_en === 1'b1) got1.push_back(fifo1_din);
        if (fifo2_rd_en === 1'b1) begin
            pops++;
            if (q2.size() > 0) void'(q2.pop_front());
        end
        if (mem_wvalid === 1'b1 && mem_wready) begin
            wgot.push_back(mem_wdata);
            wlast_q.push_back(mem_wlast);
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic do_read(input logic [31:0] addr, input bit stress, input int rst_beat, output int viol, output bit tmo);
        int idx = 0, cyc = 0, fidx = -1;
        viol = 0; tmo = 0; done_now = 0; ax_addr = '0; ax_len = '0;
        exp1.delete(); got1.delete();
        for (int i = 0; i < 8; i++) exp1.push_back({$urandom, $urandom});
        @(negedge clk); cmd_valid = 1; cmd_data = {2'b01, addr};
        do begin
            @(negedge clk); cmd_valid = 0;
            mem_arready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
            #1; cyc++;
        end while (!(mem_arvalid === 1'b1 && mem_arready) && cyc < 50);
        if (!(mem_arvalid === 1'b1 && mem_arready)) begin tmo = 1; mem_arready = 0; return; end
        ax_addr = mem_araddr; ax_len = mem_arlen; cyc = 0;
        while (idx < 8) begin
            @(negedge clk);
            mem_arready = 0;
            mem_rvalid = stress ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_rdata = exp1[idx];
            fifo1_full = stress && idx >= 3 && idx <= 5 && (idx != fidx || $urandom_range(0, 1) == 1);
            if (fifo1_full) fidx = idx;
            if (idx == rst_beat) begin rst = 1; #1; return; end
            #1;
            if (mem_rready !== !fifo1_full) viol++;
            if (fifo1_wr_en !== (mem_rvalid && !fifo1_full)) viol++;
            if (fifo1_wr_en === 1'b1) idx++;
            if (++cyc > 300) begin tmo = 1; mem_rvalid = 0; fifo1_full = 0; return; end
        end
        @(negedge clk); mem_rvalid = 0; fifo1_full = 0; #1; done_now = done;
        @(negedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, output int viol, output bit tmo);
        int acc = 0, cyc = 0;
        viol = 0; tmo = 0; done_now = 0; ax_addr = '0; ax_len = '0;
        exp2.delete(); q2.delete(); wgot.delete(); wlast_q.delete(); pops = 0;
        for (int i = 0; i < 20; i++) exp2.push_back({$urandom, $urandom});
        for (int i = 0; i < 10; i++) q2.push_back(exp2[i]);
        @(negedge clk); cmd_valid = 1; cmd_data = {2'b10, addr};
        do begin
            @(negedge clk); cmd_valid = 0; mem_awready = 1'($urandom_range(0, 1)); #1; cyc++;
        end while (!(mem_awvalid === 1'b1 && mem_awready) && cyc < 50);
        if (!(mem_awvalid === 1'b1 && mem_awready)) begin tmo = 1; mem_awready = 0; return; end
        ax_addr = mem_awaddr; ax_len = mem_awlen; cyc = 0;
        while (acc < 16) begin
            @(negedge clk);
            mem_awready = 0;
            if (cyc == 30) for (int i = 10; i < 20; i++) q2.push_back(exp2[i]);
            fifo2_empty = (q2.size() == 0);
            fifo2_dout = fifo2_empty ? 64'h0 : q2[0];
            mem_wready = ($urandom_range(0, 1) == 1);
            #1;
            if (mem_wvalid !== !fifo2_empty) viol++;
            if (fifo2_rd_en !== (!fifo2_empty && mem_wready)) viol++;
            if (mem_wlast !== (!fifo2_empty && acc == 15)) viol++;
            if (mem_wvalid === 1'b1 && mem_wdata !== fifo2_dout) viol++;
            if (mem_wvalid === 1'b1 && mem_wready) acc++;
            if (++cyc > 300) begin tmo = 1; mem_wready = 0; fifo2_empty = 1; return; end
        end
        @(negedge clk); mem_wready = 0; fifo2_empty = 1; #1; done_now = done;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        #3; rst = 1;
        @(negedge clk); #1;
        checks++; if ({mem_arvalid, mem_awvalid, done, err_op, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {mem_arvalid, mem_awvalid, done, err_op, busy}); end
        checks++; if ({mem_araddr, mem_awaddr} !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", {mem_araddr, mem_awaddr}); end
        checks++; if ({mem_rready, mem_wvalid, mem_wlast, fifo1_wr_en, fifo2_rd_en} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {mem_rready, mem_wvalid, mem_wlast, fifo1_wr_en, fifo2_rd_en}); end
        checks++; if (mem_arlen !== 8'd7 || mem_awlen !== 8'd15) begin errors++; $display("FAIL reset_len: got %0d/%0d want 7/15", mem_arlen, mem_awlen); end
        @(negedge clk); rst = 0; #1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_ready: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    endtask

    task automatic test_read_basic();
        int viol, d0; bit tmo;
        d0 = done_cnt;
        do_read(32'h1000, 0, -1, viol, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL rd_basic_timeout: got timeout want completion"); end
        checks++; if (ax_addr !== 32'h1000) begin errors++; $display("FAIL rd_araddr: got %h want 00001000", ax_addr); end
        checks++; if (ax_len !== 8'd7) begin errors++; $display("FAIL rd_arlen: got %0d want 7", ax_len); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rd_basic_handshake: got %0d violations want 0", viol); end
        checks++; if (got1.size() !== 8) begin errors++; $display("FAIL rd_basic_count: got %0d want 8", got1.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= got1.size() || got1[i] !== exp1[i]) begin errors++; $display("FAIL rd_basic_data[%0d]: got %h want %h", i, i < got1.size() ? got1[i] : 64'hx, exp1[i]); end
        end
        checks++; if (done_now !== 1'b1 || done_cnt - d0 !== 1) begin errors++; $display("FAIL rd_basic_done: got now=%b pulses=%0d want 1/1", done_now, done_cnt - d0); end
    endtask

    task automatic test_read_stall();
        int viol, d0, bad = 0; bit tmo;
        d0 = done_cnt;
        do_read(32'h1800, 1, -1, viol, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL rd_stall_timeout: got timeout want completion"); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rd_stall_handshake: got %0d violations want 0", viol); end
        for (int i = 0; i < 8; i++) if (i >= got1.size() || got1[i] !== exp1[i]) bad++;
        checks++; if (bad !== 0 || got1.size() !== 8) begin errors++; $display("FAIL rd_stall_data: got %0d bad of %0d words want 0 bad of 8", bad, got1.size()); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rd_stall_done: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_write();
        int viol, d0, bad = 0, lasts = 0; bit tmo;
        d0 = done_cnt;
        do_write(32'h2000, viol, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL wr_timeout: got timeout want completion"); end
        checks++; if (ax_addr !== 32'h2000 || ax_len !== 8'd15) begin errors++; $display("FAIL wr_aw: got %h/%0d want 00002000/15", ax_addr, ax_len); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL wr_handshake: got %0d violations want 0", viol); end
        checks++; if (pops !== 16 || q2.size() !== 4) begin errors++; $display("FAIL wr_pops: got %0d pops %0d left want 16/4", pops, q2.size()); end
        for (int i = 0; i < 16; i++) if (i >= wgot.size() || wgot[i] !== exp2[i]) bad++;
        checks++; if (bad !== 0 || wgot.size() !== 16) begin errors++; $display("FAIL wr_data: got %0d bad of %0d beats want 0 bad of 16", bad, wgot.size()); end
        foreach (wlast_q[i]) if (wlast_q[i]) lasts++;
        checks++; if (lasts !== 1 || wlast_q.size() !== 16 || !wlast_q[wlast_q.size() - 1]) begin errors++; $display("FAIL wr_wlast: got %0d lasts want 1 on beat 16", lasts); end
        checks++; if (done_now !== 1'b1 || done_cnt - d0 !== 1) begin errors++; $display("FAIL wr_done: got now=%b pulses=%0d want 1/1", done_now, done_cnt - d0); end
    endtask

    task automatic test_err_op();
        int viol, bad = 0; bit tmo;
        logic [1:0] ops [2] = '{2'b11, 2'b00};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); cmd_valid = 1; cmd_data = {ops[k], $urandom};
            @(negedge clk); cmd_valid = 0; #1;
            checks++; if (err_op !== 1'b1) begin errors++; $display("FAIL err_pulse[%b]: got %b want 1", ops[k], err_op); end
            checks++; if ({mem_arvalid, mem_awvalid, busy} !== 3'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL err_quiet[%b]: got ar/aw/busy=%b ready=%b want 000/1", ops[k], {mem_arvalid, mem_awvalid, busy}, cmd_ready); end
            @(negedge clk); #1;
            checks++; if (err_op !== 1'b0) begin errors++; $display("FAIL err_width[%b]: got %b want 0", ops[k], err_op); end
        end
        do_read(32'h4000, 0, -1, viol, tmo);
        for (int i = 0; i < 8; i++) if (i >= got1.size() || got1[i] !== exp1[i]) bad++;
        checks++; if (tmo || viol !== 0 || bad !== 0 || ax_addr !== 32'h4000) begin errors++; $display("FAIL err_next_read: got tmo=%b viol=%0d bad=%0d addr=%h want 0/0/0/00004000", tmo, viol, bad, ax_addr); end
    endtask

    task automatic test_reset_mid();
        int viol, d0, bad = 0; bit tmo;
        do_read(32'h3000, 0, 4, viol, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL mid_reach: got timeout want beat 4"); end
        checks++; if ({busy, mem_arvalid, mem_rready, fifo1_wr_en, done} !== 5'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_idle: got busy/ar/rready/wr/done=%b ready=%b want 00000/1", {busy, mem_arvalid, mem_rready, fifo1_wr_en, done}, cmd_ready); end
        checks++; if (mem_araddr !== 32'h0) begin errors++; $display("FAIL mid_araddr: got %h want 0", mem_araddr); end
        checks++; if (got1.size() !== 4) begin errors++; $display("FAIL mid_partial: got %0d words want 4", got1.size()); end
        @(negedge clk); rst = 0; mem_rvalid = 0;
        d0 = done_cnt;
        do_read(32'h3100, 1, -1, viol, tmo);
        for (int i = 0; i < 8; i++) if (i >= got1.size() || got1[i] !== exp1[i]) bad++;
        checks++; if (tmo || viol !== 0 || bad !== 0 || got1.size() !== 8) begin errors++; $display("FAIL mid_recover: got tmo=%b viol=%0d bad=%0d n=%0d want 0/0/0/8", tmo, viol, bad, got1.size()); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL mid_done: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        int viol, bad; bit tmo; logic [31:0] a;
        for (int n = 0; n < 6; n++) begin
            a = $urandom; bad = 0;
            if ($urandom_range(0, 1) == 1) begin
                do_read(a, 1, -1, viol, tmo);
                for (int i = 0; i < 8; i++) if (i >= got1.size() || got1[i] !== exp1[i]) bad++;
                checks++; if (tmo || viol !== 0 || bad !== 0 || ax_addr !== a) begin errors++; $display("FAIL rand_rd[%0d]: got tmo=%b viol=%0d bad=%0d addr=%h want 0/0/0/%h", n, tmo, viol, bad, ax_addr, a); end
            end else begin
                do_write(a, viol, tmo);
                for (int i = 0; i < 16; i++) if (i >= wgot.size() || wgot[i] !== exp2[i]) bad++;
                checks++; if (tmo || viol !== 0 || bad !== 0 || pops !== 16 || ax_addr !== a) begin errors++; $display("FAIL rand_wr[%0d]: got tmo=%b viol=%0d bad=%0d pops=%0d addr=%h want 0/0/0/16/%h", n, tmo, viol, bad, pops, ax_addr, a); end
            end
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_read_stall();
        test_write();
        test_err_op();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
